// File: rtl/st_sink_checker.sv
`default_nettype none
// ============================================================================
// Module   : st_sink_checker
// Purpose  : Parametrised Avalon-ST sink for bring-up of the F2H-SDRAM read
//            path. It generates `ready` in one of four backpressure modes and
//            checks every accepted beat against an incrementing per-lane word
//            pattern. It also keeps saturating beat and error counters and
//            captures the first error.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH      stream width; integer multiple of LANE_WIDTH
//   LANE_WIDTH      width of one pattern word
//   CNT_WIDTH       width of beat/error counters and first-error beat index
//   THROTTLE_PERIOD period of mode-1 ready pulses (>= 2)
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   st_data, valid  incoming stream beat
//   ready           registered accept, decided one cycle ahead from mode
//   mode            0 always, 1 throttle, 2 LFSR, 3 stall
//   check_en        pattern comparison enable (beats always counted)
//   seed            expected lane-0 word of beat 0, loaded on rst/clear
//   clear           synchronous clear of checker state (not ready generator)
//   beat_count      accepted beats, saturating, latency 1
//   error_count     mismatching beats, saturating, latency 2
//   error_flag      sticky first-mismatch flag
//   first_err_beat  beat index of the first mismatch
//   first_err_lanes per-lane mismatch mask of the first bad beat
// ============================================================================
module st_sink_checker #(
  parameter int DATA_WIDTH      = 256,
  parameter int LANE_WIDTH      = 32,
  parameter int CNT_WIDTH       = 32,
  parameter int THROTTLE_PERIOD = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               st_data,
  input  logic                                valid,
  output logic                                ready,
  input  logic [1:0]                          mode,
  input  logic                                check_en,
  input  logic [LANE_WIDTH-1:0]               seed,
  input  logic                                clear,
  output logic [CNT_WIDTH-1:0]                beat_count,
  output logic [CNT_WIDTH-1:0]                error_count,
  output logic                                error_flag,
  output logic [CNT_WIDTH-1:0]                first_err_beat,
  output logic [DATA_WIDTH/LANE_WIDTH-1:0]    first_err_lanes
);

  localparam int LANES   = DATA_WIDTH / LANE_WIDTH;
  localparam int PHASE_W = (THROTTLE_PERIOD > 2) ? $clog2(THROTTLE_PERIOD) : 1;

  localparam logic [PHASE_W-1:0]    PHASE_LAST = PHASE_W'(THROTTLE_PERIOD - 1);
  localparam logic [LANE_WIDTH-1:0] LANE_STEP  = LANE_WIDTH'(LANES);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;
  localparam logic [15:0]           LFSR_INIT  = 16'hACE1;

  localparam logic [1:0] MODE_ALWAYS   = 2'd0;
  localparam logic [1:0] MODE_THROTTLE = 2'd1;
  localparam logic [1:0] MODE_LFSR     = 2'd2;
  localparam logic [1:0] MODE_STALL    = 2'd3;

  // --------------------------------------------------------------------------
  // Ready generator. Phase counter and LFSR free-run in every mode so that a
  // mode switch picks up a running sequence; only rst restarts them.
  // --------------------------------------------------------------------------
  logic [PHASE_W-1:0] phase;
  logic [15:0]        lfsr;
  logic               lfsr_fb;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      phase <= '0;
      lfsr  <= LFSR_INIT;
    end else begin
      case (mode)
        MODE_ALWAYS:   ready <= 1'b1;
        MODE_THROTTLE: ready <= (phase == '0);
        MODE_LFSR:     ready <= lfsr[0];
        MODE_STALL:    ready <= 1'b0;
        default:       ready <= 1'b0;
      endcase
      phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
      lfsr  <= {lfsr_fb, lfsr[15:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Transfer qualification. A handshake coinciding with clear is discarded.
  // --------------------------------------------------------------------------
  logic xfer;
  assign xfer = valid && ready && !clear;

  // --------------------------------------------------------------------------
  // Expected pattern: lane k of the current beat is base + k. The base moves
  // on every transfer regardless of outcome; there is no resynchronisation.
  // --------------------------------------------------------------------------
  logic [LANE_WIDTH-1:0] base;
  logic [CNT_WIDTH-1:0]  beat_idx;
  logic [DATA_WIDTH-1:0] exp_vec;

  for (genvar k = 0; k < LANES; k++) begin : g_exp_lane
    assign exp_vec[k*LANE_WIDTH +: LANE_WIDTH] = base + LANE_WIDTH'(k);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      base     <= seed;
      beat_idx <= '0;
    end else if (xfer) begin
      base     <= base + LANE_STEP;
      beat_idx <= beat_idx + 1'b1;
    end
  end

  // Beat counter sits directly on the transfer, giving latency 1.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_count <= '0;
    end else if (xfer && (beat_count != CNT_MAX)) begin
      beat_count <= beat_count + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // S1: capture the beat, its expected vector and its index. Only the valid
  // bit is flushed; the payload registers are don't-care while it is low.
  // --------------------------------------------------------------------------
  logic                  s1_valid;
  logic                  s1_chk;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] s1_exp;
  logic [CNT_WIDTH-1:0]  s1_idx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_data <= st_data;
      s1_exp  <= exp_vec;
      s1_idx  <= beat_idx;
      s1_chk  <= check_en;
    end
  end

  // --------------------------------------------------------------------------
  // S2: per-lane compare feeds the error registers directly, so error state
  // becomes visible two cycles after the transfer.
  // --------------------------------------------------------------------------
  logic [LANES-1:0] lane_mis;
  logic             bad_beat;

  for (genvar k = 0; k < LANES; k++) begin : g_cmp_lane
    assign lane_mis[k] = (s1_data[k*LANE_WIDTH +: LANE_WIDTH] !=
                          s1_exp[k*LANE_WIDTH +: LANE_WIDTH]);
  end

  // check_en is the value latched with the beat, not the live input.
  assign bad_beat = s1_valid && s1_chk && (|lane_mis);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      error_count     <= '0;
      error_flag      <= 1'b0;
      first_err_beat  <= '0;
      first_err_lanes <= '0;
    end else if (bad_beat) begin
      if (error_count != CNT_MAX) begin
        error_count <= error_count + 1'b1;
      end
      // First-error capture is frozen once the sticky flag is set.
      if (!error_flag) begin
        error_flag      <= 1'b1;
        first_err_beat  <= s1_idx;
        first_err_lanes <= lane_mis;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_st_sink_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_st_sink_checker
// Purpose  : Self-checking bench for st_sink_checker. A cycle model predicts
//            ready, counters and first-error capture; accepted beats are
//            pushed to a scoreboard queue and popped when the DUT's error
//            stage is due to reflect them. Directed checks cover each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_st_sink_checker;

  localparam int DW    = 256;
  localparam int LW    = 32;
  localparam int LANES = DW / LW;
  localparam int CW    = 32;
  localparam int TP    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   st_data;
  logic            valid;
  logic [1:0]      mode;
  logic            check_en;
  logic [LW-1:0]   seed;
  logic            clear;

  logic            ready;
  logic [CW-1:0]   beat_count;
  logic [CW-1:0]   error_count;
  logic            error_flag;
  logic [CW-1:0]   first_err_beat;
  logic [LANES-1:0] first_err_lanes;

  logic            ready4;
  logic [3:0]      beat_count4;
  logic [3:0]      error_count4;
  logic            error_flag4;
  logic [3:0]      first_err_beat4;
  logic [LANES-1:0] first_err_lanes4;

  always #5 clk = ~clk;

  st_sink_checker #(
    .DATA_WIDTH(DW), .LANE_WIDTH(LW), .CNT_WIDTH(CW), .THROTTLE_PERIOD(TP)
  ) dut (
    .clk(clk), .rst(rst), .st_data(st_data), .valid(valid), .ready(ready),
    .mode(mode), .check_en(check_en), .seed(seed), .clear(clear),
    .beat_count(beat_count), .error_count(error_count), .error_flag(error_flag),
    .first_err_beat(first_err_beat), .first_err_lanes(first_err_lanes)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  st_sink_checker #(
    .DATA_WIDTH(DW), .LANE_WIDTH(LW), .CNT_WIDTH(4), .THROTTLE_PERIOD(TP)
  ) dut4 (
    .clk(clk), .rst(rst), .st_data(st_data), .valid(valid), .ready(ready4),
    .mode(mode), .check_en(check_en), .seed(seed), .clear(clear),
    .beat_count(beat_count4), .error_count(error_count4), .error_flag(error_flag4),
    .first_err_beat(first_err_beat4), .first_err_lanes(first_err_lanes4)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int               due;
    logic [LANES-1:0] mask;
    logic             bad;
    logic [CW-1:0]    idx;
  } sb_t;

  sb_t sb[$];

  // Model state
  int               cyc = 0;
  int               m_phase;
  logic [15:0]      m_lfsr;
  logic [LW-1:0]    m_base;
  logic [CW-1:0]    m_idx;
  logic             e_ready;
  logic [CW-1:0]    e_bc, e_ec, e_fbeat;
  logic             e_flag;
  logic [LANES-1:0] e_flanes;
  logic [3:0]       e_bc4, e_ec4, e_fbeat4;

  // Stimulus generator state
  logic [LW-1:0]    gen_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [DW-1:0] mk(input logic [LW-1:0] b,
                                       input logic [LANES-1:0] badm,
                                       input logic [LW-1:0] bv);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      v[k*LW +: LW] = badm[k] ? bv : b + LW'(k);
    end
    return v;
  endfunction

  task automatic model_zero();
    e_bc = '0; e_ec = '0; e_fbeat = '0; e_flag = 1'b0; e_flanes = '0;
    e_bc4 = '0; e_ec4 = '0; e_fbeat4 = '0;
    m_idx = '0;
    m_base = seed;
    sb.delete();
  endtask

  // Called right after each rising edge: inputs and DUT outputs still hold
  // the values of the cycle that just ended.
  task automatic model_edge();
    if (rst) begin
      e_ready = 1'b0;
      m_phase = 0;
      m_lfsr  = 16'hACE1;
      model_zero();
    end else begin
      case (mode)
        2'd0:    e_ready = 1'b1;
        2'd1:    e_ready = (m_phase == 0);
        2'd2:    e_ready = m_lfsr[0];
        default: e_ready = 1'b0;
      endcase
      m_phase = (m_phase + 1) % TP;
      m_lfsr  = lfsr_nx(m_lfsr);
      if (clear) begin
        model_zero();
      end else begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          sb_t e;
          e = sb.pop_front();
          if (e.bad) begin
            if (e_ec != '1) e_ec = e_ec + 1;
            if (e_ec4 != 4'hF) e_ec4 = e_ec4 + 1;
            if (!e_flag) begin
              e_flag   = 1'b1;
              e_fbeat  = e.idx;
              e_fbeat4 = e.idx[3:0];
              e_flanes = e.mask;
            end
          end
        end
        if (valid && ready) begin
          sb_t n;
          n.due = cyc + 1;
          n.idx = m_idx;
          for (int k = 0; k < LANES; k++) begin
            n.mask[k] = (st_data[k*LW +: LW] != m_base + LW'(k));
          end
          n.bad = check_en && (|n.mask);
          sb.push_back(n);
          m_base = m_base + LW'(LANES);
          m_idx  = m_idx + 1;
          if (e_bc != '1) e_bc = e_bc + 1;
          if (e_bc4 != 4'hF) e_bc4 = e_bc4 + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("ready", 64'(ready), 64'(e_ready));
    chk("beat_count", 64'(beat_count), 64'(e_bc));
    chk("error_count", 64'(error_count), 64'(e_ec));
    chk("error_flag", 64'(error_flag), 64'(e_flag));
    chk("first_err_beat", 64'(first_err_beat), 64'(e_fbeat));
    chk("first_err_lanes", 64'(first_err_lanes), 64'(e_flanes));
    chk("beat_count4", 64'(beat_count4), 64'(e_bc4));
    chk("error_count4", 64'(error_count4), 64'(e_ec4));
    chk("first_err_beat4", 64'(first_err_beat4), 64'(e_fbeat4));
    chk("error_flag4", 64'(error_flag4), 64'(e_flag));
  endtask

  // One clock: model update at the edge, full comparison mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Offer beats until n are accepted. bad_beat: -1 none, -2 every beat,
  // otherwise the index (within this call) of the corrupted beat.
  task automatic beats(input int n, input int bad_beat,
                       input logic [LANES-1:0] badm, input logic [LW-1:0] bv);
    int  got;
    int  c;
    logic will;
    got = 0;
    c   = 0;
    while (got < n && c < n * 8 + 16) begin
      valid   = 1'b1;
      st_data = mk(gen_base,
                   (bad_beat == -2 || bad_beat == got) ? badm : '0, bv);
      will    = ready;
      tick();
      if (will) begin
        got++;
        gen_base = gen_base + LW'(LANES);
      end
      c++;
    end
    valid = 1'b0;
    if (got < n) chk("beats_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    logic [15:0] ref_l;
    int          ones;
    logic        will;

    rst = 1'b1; valid = 1'b0; clear = 1'b0; mode = 2'd0; check_en = 1'b1;
    seed = '0; st_data = '0; gen_base = '0;
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    chk("rst_error_flag", 64'(error_flag), 64'd0);
    chk("rst_first_err_lanes", 64'(first_err_lanes), 64'd0);

    // Mode 0, seed 0, 8 correct beats
    rst = 1'b0;
    gen_base = seed;
    tick();
    chk("t1_ready_first", 64'(ready), 64'd1);
    beats(8, -1, '0, '0);
    tick(); tick(); tick();
    chk("t1_beat_count", 64'(beat_count), 64'd8);
    chk("t1_error_count", 64'(error_count), 64'd0);
    chk("t1_error_flag", 64'(error_flag), 64'd0);

    // Seed 0x100, beat 2 lane 5 corrupted
    seed = 32'h100; clear = 1'b1;
    tick();
    clear = 1'b0; gen_base = seed;
    beats(2, -1, '0, '0);
    beats(1, 0, 8'h20, 32'hDEAD);
    chk("t2_flag_lat1", 64'(error_flag), 64'd0);
    tick();
    chk("t2_flag_lat2", 64'(error_flag), 64'd1);
    beats(1, -1, '0, '0);
    tick(); tick(); tick();
    chk("t2_beat_count", 64'(beat_count), 64'd4);
    chk("t2_error_count", 64'(error_count), 64'd1);
    chk("t2_first_err_beat", 64'(first_err_beat), 64'd2);
    chk("t2_first_err_lanes", 64'(first_err_lanes), 64'h20);

    // Mode 1 throttle for 20 cycles, then mode 3 stall
    seed = '0; clear = 1'b1;
    tick();
    clear = 1'b0; gen_base = seed; mode = 2'd1;
    tick();
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      valid = 1'b1;
      st_data = mk(gen_base, '0, '0);
      will = ready;
      if (will) ones++;
      tick();
      if (will) gen_base = gen_base + LW'(LANES);
    end
    valid = 1'b0;
    tick();
    chk("t3_ready_pulses", 64'(ones), 64'd5);
    chk("t3_beat_count", 64'(beat_count), 64'd5);
    mode = 2'd3;
    tick();
    for (int i = 0; i < 10; i++) begin
      valid = 1'b1;
      st_data = mk(gen_base, '0, '0);
      chk("t3_stall_ready", 64'(ready), 64'd0);
      tick();
    end
    valid = 1'b0;
    tick();
    chk("t3_stall_beat_count", 64'(beat_count), 64'd5);

    // Mode 2 LFSR after rst, 64 cycles against the reference sequence
    rst = 1'b1; mode = 2'd2; seed = '0;
    tick(); tick();
    rst = 1'b0; gen_base = seed;
    tick();
    ref_l = 16'hACE1;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      chk("t4_lfsr_ready", 64'(ready), 64'(ref_l[0]));
      if (ref_l[0]) ones++;
      ref_l = lfsr_nx(ref_l);
      valid = 1'b1;
      st_data = mk(gen_base, '0, '0);
      will = ready;
      tick();
      if (will) gen_base = gen_base + LW'(LANES);
    end
    valid = 1'b0;
    tick(); tick();
    chk("t4_xfer_count", 64'(beat_count), 64'(ones));
    chk("t4_error_count", 64'(error_count), 64'd0);

    // Seed wrap through zero, then counter saturation on the narrow instance
    mode = 2'd0; seed = 32'hFFFF_FFFE; clear = 1'b1;
    tick();
    clear = 1'b0; gen_base = seed;
    beats(2, -1, '0, '0);
    tick(); tick();
    chk("t5_wrap_error_count", 64'(error_count), 64'd0);
    chk("t5_wrap_beat_count", 64'(beat_count), 64'd2);
    beats(16, -1, '0, '0);
    tick();
    chk("t5_beat_count", 64'(beat_count), 64'd18);
    chk("t5_beat_count4_sat", 64'(beat_count4), 64'd15);
    seed = '0; clear = 1'b1;
    tick();
    clear = 1'b0; gen_base = seed;
    beats(18, -2, 8'h01, 32'hDEAD);
    tick(); tick();
    chk("t5_error_count", 64'(error_count), 64'd18);
    chk("t5_error_count4_sat", 64'(error_count4), 64'd15);
    chk("t5_first_err_beat", 64'(first_err_beat), 64'd0);
    chk("t5_first_err_lanes", 64'(first_err_lanes), 64'h01);

    // Bad beat, clear with a coincident transfer, then 3 correct beats
    seed = 32'h40; clear = 1'b1;
    tick();
    clear = 1'b0; gen_base = seed;
    beats(1, 0, 8'h08, 32'hBAD0);
    clear = 1'b1; valid = 1'b1; st_data = mk(gen_base, 8'hFF, 32'h1234);
    chk("t6_clear_ready", 64'(ready), 64'd1);
    tick();
    clear = 1'b0; valid = 1'b0; gen_base = seed;
    beats(3, -1, '0, '0);
    tick(); tick(); tick();
    chk("t6_beat_count", 64'(beat_count), 64'd3);
    chk("t6_error_count", 64'(error_count), 64'd0);
    chk("t6_error_flag", 64'(error_flag), 64'd0);
    chk("t6_first_err_lanes", 64'(first_err_lanes), 64'd0);

    // check_en low: bad data is counted but not flagged
    check_en = 1'b0;
    beats(2, -2, 8'hFF, 32'h5555);
    check_en = 1'b1;
    tick(); tick(); tick();
    chk("t6_nochk_beat_count", 64'(beat_count), 64'd5);
    chk("t6_nochk_error_count", 64'(error_count), 64'd0);
    chk("t6_nochk_error_flag", 64'(error_flag), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/st_sink_checker.md
# st_sink_checker

Parametrised Avalon-ST sink that replaces the fixed test sink on the mSGDMA stream-source path. It generates `ready` in one of four backpressure modes and checks every accepted beat against an incrementing per-lane word pattern. It also keeps saturating beat and error counters plus first-error capture, for bring-up of the F2H-SDRAM read path at any stream width.

## Interface
- DATA_WIDTH, 256, stream data width; must be an integer multiple of LANE_WIDTH.
- LANE_WIDTH, 32, width of one pattern word; LANES = DATA_WIDTH/LANE_WIDTH.
- CNT_WIDTH, 32, width of the beat and error counters.
- THROTTLE_PERIOD, 4, period of mode-1 ready pulses; must be ≥2.
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- st_data  in  DATA_WIDTH  stream data; lane k = bits [k*LANE_WIDTH +: LANE_WIDTH].
- valid  in  1  source has a beat.
- ready  out  1  sink accepts; registered; reset 0.
- mode  in  2  ready mode: 0 = always, 1 = throttle, 2 = LFSR, 3 = stall.
- check_en  in  1  enables pattern comparison; beats are still counted when low.
- seed  in  LANE_WIDTH  expected value of lane 0, beat 0; sampled on rst or clear.
- clear  in  1  synchronous clear of checker state.
- beat_count  out  CNT_WIDTH  accepted beats; reset 0.
- error_count  out  CNT_WIDTH  mismatching beats; reset 0.
- error_flag  out  1  sticky; set on the first mismatch; reset 0.
- first_err_beat  out  CNT_WIDTH  beat index of the first mismatch; reset 0.
- first_err_lanes  out  LANES  per-lane mismatch mask of the first bad beat; reset 0.

## Operation
- A transfer occurs when `valid && ready` in the same cycle. No other cycle is a transfer.
- Ready generator is registered, so the next-cycle value is decided from the current mode:
  - mode 0: 1.
  - mode 1: phase counter 0..THROTTLE_PERIOD-1 wraps; ready = 1 when phase == 0.
  - mode 2: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifts every cycle, reset value 16'hACE1; ready = lfsr[0].
  - mode 3: 0.
  - Phase counter and LFSR run free regardless of mode. Both are reset only by rst, not by clear.
- Expected pattern for beat n, lane k: (base + n*LANES + k) mod 2^LANE_WIDTH.
  - base loads from `seed` on rst or clear.
  - Next-beat base = base + LANES after each transfer, wrapping modulo 2^LANE_WIDTH.
- Checker pipeline:
  - S1: register the transferred data, the expected vector and the beat index; assert s1_valid.
  - S2: compare per lane to form the mismatch mask. The beat is bad if the mask is nonzero and check_en was high at transfer time.
- On a bad beat:
  - error_count increments.
  - If error_flag is 0: set error_flag, capture first_err_beat and first_err_lanes.
- Both counters saturate at all-ones and never wrap.
- Expected base advances on every transfer, whether or not it was bad. The checker does not resynchronise to the data.
- clear: zeroes beat_count, error_count, error_flag, first_err_* and the beat index; flushes S1/S2 valids; reloads base from seed.
  - A transfer in the same cycle as clear is discarded and not counted.
  - Ready generation is unaffected.
- rst: every output goes to its reset value, LFSR = 16'hACE1, phase = 0, pipelines are flushed. A beat in flight is dropped.

## Timing
- ready: 1 cycle after rst deasserts, ready follows mode (mode 0 gives ready = 1 in the first cycle after rst low).
- Mode change takes effect on ready in the following cycle.
- beat_count: updates the cycle after the transfer (latency 1).
- error_count, error_flag, first_err_*: update 2 cycles after the transfer (latency 2).
- Throughput: one beat per cycle, no internal stall.
- Back-to-back bad beats each increment error_count. first_err_* are frozen after the first bad beat until clear or rst.

## Test plan
- Mode 0, seed=0, 8 beats carrying correct pattern (beat 0 lanes = 0..7, beat 1 = 8..15, …) → ready=1 continuously, beat_count=8, error_count=0, error_flag=0.
- Mode 0, seed=0x100, 4 beats with beat 2 lane 5 = 0xDEAD (expected 0x115) → error_count=1, error_flag=1 exactly 2 cycles after beat 2, first_err_beat=2, first_err_lanes=8'b0010_0000.
- Mode 1, THROTTLE_PERIOD=4, valid held high, 20 cycles → ready pulses 1-in-4, beat_count=5; mode 3 → ready=0 and beat_count frozen.
- Mode 2 after rst → ready sequence matches the reference LFSR from 16'hACE1 bit-for-bit for 64 cycles; count of transfers equals count of ready=1 cycles with valid high.
- Seed=0xFFFF_FFFE, 2 correct beats → lane values wrap through 0, error_count=0. Force beat_count preset near max (CNT_WIDTH=4) → saturates at 15.
- Bad beat, then clear asserted together with a transfer, then 3 correct beats → error state zeroed, beat_count=3, discarded beat not counted, no error; check_en=0 with bad data → beat_count increments, error_count stays 0.
